// File: rtl/adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : adder_pkg
//  Purpose : Shared definitions for the adder result FIFO. These are the
//            entry width, the default sizing parameters, the bit positions of
//            the fields inside a stored entry, and a helper that packs one
//            entry.
//  Entry   : {sum[5:2], cout[1], ovf[0]}
//  Rev     : 1.0  initial release
// ============================================================================
package adder_pkg;

    localparam int RES_W         = 6;   // width of one stored result entry
    localparam int DEPTH_DEFAULT = 4;   // default number of buffered entries
    localparam int CNT_W_DEFAULT = 8;   // default event counter width

    localparam int SUM_MSB  = 5;
    localparam int SUM_LSB  = 2;
    localparam int COUT_BIT = 1;
    localparam int OVF_BIT  = 0;

    // Build a storage entry from the individual adder result fields.
    function automatic logic [RES_W-1:0] pack_result(
        input logic [3:0] sum,
        input logic       cout,
        input logic       ovf
    );
        logic [RES_W-1:0] r;
        r                   = '0;
        r[SUM_MSB:SUM_LSB]  = sum;
        r[COUT_BIT]         = cout;
        r[OVF_BIT]          = ovf;
        return r;
    endfunction

endpackage : adder_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module  : sat_counter
//  Purpose : Saturating event counter. It holds at the all-ones value instead
//            of wrapping. A synchronous clear takes priority over a
//            coincident increment.
//  Ports   : clk    - clock
//            rst_n  - asynchronous active-low reset
//            inc    - count one event this cycle
//            clr    - synchronous clear to zero
//            count  - current count value
//  Rev     : 1.0  initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] c_max = '1;

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/adder_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : adder_result_fifo
//  Purpose : Small first-word-fall-through FIFO that buffers 4-bit adder
//            results (sum, carry-out, signed overflow). It also counts the
//            accepted results that carried a carry-out or an overflow.
//  Ports   : clk, rst_n             - clock, asynchronous active-low reset
//            in_valid/in_ready      - upstream handshake
//            in_sum/in_cout/in_ovf  - upstream result fields
//            out_valid/out_ready    - downstream handshake
//            out_sum/out_cout/out_ovf - head entry fields
//            level                  - number of stored entries, 0..DEPTH
//            carry_cnt/ovf_cnt      - saturating event counters
//            clr_cnt                - synchronous clear of both counters
//  Rev     : 1.0  initial release
// ============================================================================
module adder_result_fifo
    import adder_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [3:0]               in_sum,
    input  logic                     in_cout,
    input  logic                     in_ovf,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [3:0]               out_sum,
    output logic                     out_cout,
    output logic                     out_ovf,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         carry_cnt,
    output logic [CNT_W-1:0]         ovf_cnt,
    input  logic                     clr_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    localparam logic [LVL_W-1:0] c_full_level = LVL_W'(DEPTH);

    logic [RES_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic             w_push;
    logic             w_pop;
    logic [RES_W-1:0] w_head;

    // Handshake flags come only from the registered level, so in_ready has
    // no combinational path from out_ready.
    assign in_ready  = (r_level != c_full_level);
    assign out_valid = (r_level != '0);

    assign w_push = in_valid  && in_ready;
    assign w_pop  = out_valid && out_ready;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage is not reset: entries are only visible while level covers
    // them, so clearing the pointers and level is enough to discard them.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= pack_result(in_sum, in_cout, in_ovf);
        end
    end

    // The head is read straight from storage, so a pushed entry becomes
    // visible one edge after the push. There is no bypass path.
    assign w_head   = r_mem[r_rd_ptr];
    assign out_sum  = w_head[SUM_MSB:SUM_LSB];
    assign out_cout = w_head[COUT_BIT];
    assign out_ovf  = w_head[OVF_BIT];
    assign level    = r_level;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_carry_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_push && in_cout),
        .clr   (clr_cnt),
        .count (carry_cnt)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (w_push && in_ovf),
        .clr   (clr_cnt),
        .count (ovf_cnt)
    );

endmodule : adder_result_fifo
`default_nettype wire

// File: tb/tb_adder_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module  : tb_adder_result_fifo
//  Purpose : Self-checking bench for adder_result_fifo with a queue-based
//            reference model of contents, level and counters.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_adder_result_fifo;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_sum;
    logic             in_cout;
    logic             in_ovf;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic [2:0]       level;
    logic [CNT_W-1:0] carry_cnt;
    logic [CNT_W-1:0] ovf_cnt;
    logic             clr_cnt;

    adder_result_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_cout   (in_cout),
        .in_ovf    (in_ovf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .level     (level),
        .carry_cnt (carry_cnt),
        .ovf_cnt   (ovf_cnt),
        .clr_cnt   (clr_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [5:0] q[$];
    int         m_carry = 0;
    int         m_ovf   = 0;
    int         n_checks = 0;
    int         n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Compare all outputs against the model, then advance one clock edge.
    // Called #1 after an edge with the inputs for the coming edge applied.
    task automatic cycle();
        bit         do_push;
        bit         do_pop;
        logic [5:0] e;
        do_push = rst_n && in_valid && (q.size() < DEPTH);
        do_pop  = rst_n && out_ready && (q.size() != 0);
        check("in_ready",  32'(in_ready),  32'(q.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("level",     32'(level),     32'(q.size()));
        check("carry_cnt", 32'(carry_cnt), 32'(m_carry));
        check("ovf_cnt",   32'(ovf_cnt),   32'(m_ovf));
        if (do_pop) begin
            e = q.pop_front();
            check("out_sum",  32'(out_sum),  32'(e[5:2]));
            check("out_cout", 32'(out_cout), 32'(e[1]));
            check("out_ovf",  32'(out_ovf),  32'(e[0]));
        end
        if (do_push) q.push_back({in_sum, in_cout, in_ovf});
        if (rst_n) begin
            if (clr_cnt) begin
                m_carry = 0;
                m_ovf   = 0;
            end else if (do_push) begin
                if (in_cout && m_carry < CMAX) m_carry++;
                if (in_ovf  && m_ovf   < CMAX) m_ovf++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s, input logic c, input logic o);
        in_valid = v;
        in_sum   = s;
        in_cout  = c;
        in_ovf   = o;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH && q.size() != 0; i++) cycle();
        cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        out_ready = 1'b0;
        clr_cnt   = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        #1;
        // Reset state
        cycle();
        cycle();
        rst_n = 1'b1;

        // Two pushes drained in order, counters stay zero
        out_ready = 1'b1;
        drive(1'b1, 4'b0010, 1'b0, 1'b0); cycle();
        drive(1'b1, 4'b0011, 1'b0, 1'b0); cycle();
        drive(1'b0, 4'b0000, 1'b0, 1'b0); cycle();
        cycle();

        // Fill to full with consumer stalled; fifth result held upstream
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'(4 + i), 1'b0, 1'b0);
            cycle();
        end
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level",    32'(level),    32'd4);
        out_ready = 1'b1;
        cycle();                       // pop only
        check("ready_after_pop", 32'(in_ready), 32'd1);
        cycle();                       // held fifth result accepted
        drain();

        // Counter accumulation
        drive(1'b1, 4'b1110, 1'b1, 1'b0); cycle();
        drive(1'b1, 4'b1111, 1'b1, 1'b0); cycle();
        drive(1'b1, 4'b0000, 1'b0, 1'b1); cycle();
        drive(1'b1, 4'b1000, 1'b1, 1'b1); cycle();
        drain();
        check("carry_cnt_3", 32'(carry_cnt), 32'd3);
        check("ovf_cnt_2",   32'(ovf_cnt),   32'd2);

        // Saturation, then clear colliding with a carry push
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 4'(i), 1'b1, 1'b1);
            cycle();
        end
        check("carry_sat", 32'(carry_cnt), 32'd255);
        check("ovf_sat",   32'(ovf_cnt),   32'd255);
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        check("carry_clr", 32'(carry_cnt), 32'd0);
        check("ovf_clr",   32'(ovf_cnt),   32'd0);
        drain();

        // Steady push+pop at level 2 across pointer wrap
        out_ready = 1'b0;
        drive(1'b1, 4'hA, 1'b0, 1'b1); cycle();
        drive(1'b1, 4'hB, 1'b1, 1'b0); cycle();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 4'(i * 3 + 1), 1'(i), 1'(i >> 1));
            cycle();
            check("level_steady", 32'(level), 32'd2);
        end
        drain();

        // Asynchronous reset with three entries stored
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 4'(9 + i), 1'b1, 1'b0);
            cycle();
        end
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        check("pre_reset_level", 32'(level), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_level",     32'(level),     32'd0);
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_in_ready",  32'(in_ready),  32'd1);
        check("async_carry",     32'(carry_cnt), 32'd0);
        q.delete();
        m_carry = 0;
        m_ovf   = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First edge after reset release accepts a push
        drive(1'b1, 4'b0101, 1'b1, 1'b1); cycle();
        drive(1'b0, 4'h0, 1'b0, 1'b0);
        check("post_reset_level", 32'(level), 32'd1);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_adder_result_fifo
`default_nettype wire

// File: doc/adder_result_fifo.md
ADDER_RESULT_FIFO -- requirements
Module: adder_result_fifo

Interface
REQ-001: Parameter DEPTH, default 4, number of result entries buffered; power of two, 2..16.
REQ-002: Parameter CNT_W, default 8, width of each event counter.
REQ-003: clk  input  1  single clock; all state updates on rising edge.
REQ-004: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005: in_valid  input  1  upstream 4-bit adder result present.
REQ-006: in_ready  output  1  block can accept a result this cycle.
REQ-007: in_sum  input  4  adder sum.
REQ-008: in_cout  input  1  adder unsigned carry-out.
REQ-009: in_ovf  input  1  adder signed overflow.
REQ-010: out_valid  output  1  head entry available.
REQ-011: out_ready  input  1  consumer takes head entry this cycle.
REQ-012: out_sum / out_cout / out_ovf  output  4/1/1  head entry fields.
REQ-013: level  output  $clog2(DEPTH)+1  current entry count, 0..DEPTH.
REQ-014: carry_cnt  output  CNT_W  accepted results with cout=1.
REQ-015: ovf_cnt  output  CNT_W  accepted results with ovf=1.
REQ-016: clr_cnt  input  1  synchronous clear of both counters.

Function
REQ-017: Push when in_valid && in_ready; stores {in_sum,in_cout,in_ovf} at write pointer; write pointer increments mod DEPTH.
REQ-018: Pop when out_valid && out_ready; read pointer increments mod DEPTH.
REQ-019: in_ready = (level != DEPTH), combinational from registered level only; never depends on out_ready.
REQ-020: out_valid = (level != 0); out_* show entry at read pointer (first-word fall-through from registered storage).
REQ-021: Latency: result pushed into empty FIFO at edge N appears with out_valid=1 after edge N; no same-cycle bypass.
REQ-022: Simultaneous push and pop (neither empty nor full): both occur, level unchanged.
REQ-023: Full: in_ready=0, in_* ignored; pop still allowed, in_ready=1 the cycle after.
REQ-024: Empty: out_ready ignored, pointers unchanged; out_* value don't-care but stable.
REQ-025: Pointer wrap: after DEPTH pushes and pops, order preserved strictly FIFO.
REQ-026: On accepted push, carry_cnt += in_cout, ovf_cnt += in_ovf; each saturates at 2^CNT_W-1, no wrap.
REQ-027: clr_cnt=1 sets both counters to 0 next edge; clear beats a coincident increment (increment discarded); FIFO contents unaffected.
REQ-028: Counter/flag updates do not depend on pop activity.

Reset
REQ-029: rst_n low: level=0, pointers=0, carry_cnt=0, ovf_cnt=0, out_valid=0, in_ready=1, immediately (asynchronous).
REQ-030: Reset mid-operation discards all stored entries; storage array itself need not be reset.
REQ-031: First push accepted on first rising edge with rst_n high.

Structure
REQ-032: Shared package adder_pkg holds RES_W=6 entry width, default DEPTH and CNT_W, and field bit positions {sum[5:2],cout[1],ovf[0]}.
REQ-033: One sub-module sat_counter (inc, clr, CNT_W param), instantiated twice for carry_cnt and ovf_cnt.

Verification
REQ-034: Reset, push 0010/0/0 then 0011/0/0, out_ready=1 -> out_sum 0010 then 0011 in order, level 1,1→0, counters 0.
REQ-035: out_ready=0, push 5 results -> 4 accepted, in_ready=0 with level=4, 5th held upstream; one pop -> in_ready=1 next cycle.
REQ-036: Push 1110/1/0, 1111/1/0, 0000/0/1, 1000/1/1 -> carry_cnt=3, ovf_cnt=2.
REQ-037: Counter at 255, push cout=1 -> stays 255; clr_cnt=1 same cycle as cout=1 push -> 0.
REQ-038: level=2, simultaneous push and pop for 10 cycles -> level stays 2, output order matches input across pointer wrap.
REQ-039: rst_n low for one cycle with level=3 -> level=0, out_valid=0, in_ready=1 without waiting for clk edge.
